// File: rtl/demux2_stream.sv
// Two-way stream demultiplexer: in_sel steers each accepted word into one of two
// independent 2-entry FIFOs, each with a registered head word and an acceptance counter.
module demux2_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic             busy
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic accept;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [CW-1:0]    cnt;
    logic             sink_ready;
    logic             push;
    logic             pop;
    logic             valid;
    logic             full;

    assign sink_ready = (k == 0) ? out0_ready : out1_ready;
    assign valid      = (state != EMPTY);
    assign full       = (state == FULL);
    assign push       = accept && (in_sel == 1'(k));
    assign pop        = valid && sink_ready;

    // head is the oldest word; tail only holds the second word while FULL
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= EMPTY;
        head  <= '0;
        tail  <= '0;
        cnt   <= '0;
      end else begin
        if (push) cnt <= cnt + CW'(1);
        unique case (state)
          EMPTY: begin
            if (push) begin
              head  <= in_data;
              state <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              head <= in_data;
            end else if (push) begin
              tail  <= in_data;
              state <= FULL;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            // in_ready is low for this channel, so only a pop can happen here
            if (pop) begin
              head  <= tail;
              state <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // Readiness looks only at the selected channel's occupancy, never at the sinks
  assign in_ready = in_sel ? !g_ch[1].full : !g_ch[0].full;
  assign accept   = in_valid && in_ready;

  assign out0_valid = g_ch[0].valid;
  assign out1_valid = g_ch[1].valid;
  assign out0_data  = g_ch[0].head;
  assign out1_data  = g_ch[1].head;
  assign cnt0       = g_ch[0].cnt;
  assign cnt1       = g_ch[1].cnt;
  assign busy       = g_ch[0].valid || g_ch[1].valid;

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: directed stimulus feeds per-channel expectation queues,
// a negedge monitor pops and checks every output transfer.
module tb_demux2_stream;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out1_valid;
  logic        out0_ready;
  logic        out1_ready;
  logic [31:0] out0_data;
  logic [31:0] out1_data;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  demux2_stream #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; expected word is queued at acceptance
  task automatic send(input logic sel, input logic [31:0] d, output int waited);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
        break;
      end
      waited++;
      if (waited >= 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: word %h never accepted on channel %0d", d, sel);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: every transfer must match the oldest queued word of its channel
  always @(negedge clk) begin
    if (!reset) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out0_unexpected: got %h expected no word", out0_data);
        end else begin
          chk("out0_order", out0_data, q0.pop_front());
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out1_unexpected: got %h expected no word", out1_data);
        end else begin
          chk("out1_order", out1_data, q1.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);

    // Backpressure on channel 0: third word waits until a slot frees
    send(1'b0, 32'h11, w);
    chk("bp_w1_wait", 32'(w), 0);
    send(1'b0, 32'h22, w);
    chk("bp_w2_wait", 32'(w), 0);
    fork
      send(1'b0, 32'h33, w);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 32'(in_ready), 0);
          chk("bp_head_hold", out0_data, 32'h11);
        end
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_passthrough", 32'(in_ready), 0);
      end
    join
    chk("bp_cnt0", 32'(cnt0), 3);
    repeat (3) tick();
    chk("bp_drained_valid", 32'(out0_valid), 0);
    chk("bp_drained_busy", 32'(busy), 0);

    // Cross-channel independence: channel 0 full, channel 1 still accepts
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 32'h44, w);
    send(1'b0, 32'h55, w);
    send(1'b1, 32'h66, w);
    chk("xc_ch1_wait", 32'(w), 0);
    chk("xc_out0_data", out0_data, 32'h44);
    chk("xc_cnt0", 32'(cnt0), 5);
    chk("xc_cnt1", 32'(cnt1), 1);
    chk("xc_out1_valid", 32'(out1_valid), 1);
    chk("xc_out1_data", out1_data, 32'h66);
    send(1'b1, 32'h77, w);
    in_sel = 1'b0;
    @(negedge clk);
    chk("xc_sel0_full", 32'(in_ready), 0);
    chk("xc_busy", 32'(busy), 1);

    // Reset with both channels full overrides a pending push and pops
    @(posedge clk);
    #1;
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'h99;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    q0.delete();
    q1.delete();
    tick();
    chk("rf_out0_valid", 32'(out0_valid), 0);
    chk("rf_out1_valid", 32'(out1_valid), 0);
    chk("rf_busy", 32'(busy), 0);
    chk("rf_cnt0", 32'(cnt0), 0);
    chk("rf_cnt1", 32'(cnt1), 0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rf_no_accept_cnt0", 32'(cnt0), 0);
    chk("rf_out0_data", out0_data, 0);
    chk("rf_in_ready", 32'(in_ready), 1);

    // Routing with ready sinks and single-cycle latency
    send(1'b0, 32'hA5A5A5A5, w);
    chk("rt_out0_valid", 32'(out0_valid), 1);
    chk("rt_out0_data", out0_data, 32'hA5A5A5A5);
    send(1'b1, 32'h5A5A5A5A, w);
    chk("rt_out1_valid", 32'(out1_valid), 1);
    chk("rt_out1_data", out1_data, 32'h5A5A5A5A);
    chk("rt_out0_popped", 32'(out0_valid), 0);
    chk("rt_cnt0", 32'(cnt0), 1);
    chk("rt_cnt1", 32'(cnt1), 1);

    // Streaming push+pop on channel 1 while in state ONE
    send(1'b1, 32'd100, w);
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, 32'(100 + i), w);
      chk("pp_wait", 32'(w), 0);
      chk("pp_out1_valid", 32'(out1_valid), 1);
      chk("pp_out1_head", out1_data, 32'(100 + i));
    end
    chk("pp_cnt1", 32'(cnt1), 10);
    repeat (3) tick();
    chk("pp_idle_busy", 32'(busy), 0);

    // Counter wrap after 65536 pushes to channel 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    out0_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      send(1'b0, 32'(i), w);
      if (i == 65534) chk("wrap_cnt0_max", 32'(cnt0), 32'h0000FFFF);
    end
    chk("wrap_cnt0_zero", 32'(cnt0), 0);
    chk("wrap_cnt1", 32'(cnt1), 0);

    begin
      int guard;
      guard = 0;
      while ((busy || q0.size() != 0 || q1.size() != 0) && guard < 20) begin
        tick();
        guard++;
      end
    end
    chk("end_q0_empty", 32'(q0.size()), 0);
    chk("end_q1_empty", 32'(q1.size()), 0);
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  source presents a word.
REQ-005 in_ready  output  1  block accepts the presented word this cycle.
REQ-006 in_data  input  WIDTH  source word.
REQ-007 in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1.
REQ-008 out0_valid, out1_valid  output  1 each  channel holds a word for its sink.
REQ-009 out0_ready, out1_ready  input  1 each  sink takes the head word this cycle.
REQ-010 out0_data, out1_data  output  WIDTH each  head word of channel.
REQ-011 cnt0, cnt1  output  16 each  words accepted into channel since reset.
REQ-012 busy  output  1  high while either channel buffer is non-empty.

Function
REQ-013 Input transfer occurs in a cycle iff in_valid && in_ready; output transfer on channel k iff outk_valid && outk_ready.
REQ-014 Each channel has a private 2-entry FIFO; per-channel state EMPTY (0 words), ONE (1), FULL (2).
REQ-015 in_ready is combinational: high iff the channel selected by in_sel is not FULL; it never depends on outk_ready (no pass-through when FULL).
REQ-016 Source holds in_data and in_sel stable while in_valid is high and in_ready is low.
REQ-017 outk_valid is high iff channel k is not EMPTY; outk_data is the oldest word in channel k, driven from a register.
REQ-018 Latency: a word accepted at edge N is visible on outk_valid/outk_data after edge N, i.e. in cycle N+1; no combinational path from in_data to outk_data.
REQ-019 Transitions per channel: push only -> EMPTY->ONE, ONE->FULL; pop only -> FULL->ONE, ONE->EMPTY; push and pop same cycle -> state unchanged, popped word replaced in order.
REQ-020 Push and pop on the same channel in state ONE: head becomes the new word after the edge; outk_valid stays high.
REQ-021 Words leave each channel in acceptance order; no ordering relation between channels.
REQ-022 Non-selected channel is unaffected by input transfers; both channels may pop in the same cycle.
REQ-023 outk_data holds its value while outk_valid && !outk_ready (no change under backpressure).
REQ-024 cntk increments by 1 on each input transfer to channel k; wraps 16'hFFFF -> 16'h0000.
REQ-025 busy = out0_valid || out1_valid.
REQ-026 in_valid low: no state change in input side regardless of in_sel.

Reset
REQ-027 While reset is high at a rising edge: both channels -> EMPTY, cnt0 = cnt1 = 0, all buffered words discarded.
REQ-028 Outputs during/after reset: out0_valid = out1_valid = 0, busy = 0, out0_data = out1_data = 0, in_ready = 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-transfer overrides any push/pop in that cycle; the word presented is not accepted and cnt does not increment.

Verification
REQ-030 Route: in_sel=0 data 32'hA5A5A5A5, next cycle in_sel=1 data 32'h5A5A5A5A, sinks ready -> out0 gets A5A5A5A5 one cycle after acceptance, out1 gets 5A5A5A5A, cnt0=1, cnt1=1.
REQ-031 Backpressure: out0_ready=0, push 3 words to channel 0 -> first two accepted, in_ready low on third, out0_data stays first word; raise out0_ready -> words drain in order, third accepted after a slot frees.
REQ-032 Cross-channel independence: channel 0 FULL, in_sel=1 with in_valid -> in_ready=1, word enters channel 1, channel 0 unchanged.
REQ-033 Simultaneous push/pop in ONE on channel 1 for 8 cycles with incrementing data -> out1_valid continuously high, data sequence intact, cnt1=8 (+1 initial).
REQ-034 Reset with both channels FULL and cnt0=5 -> after edge all valid low, busy=0, cnts=0, in_ready=1.
REQ-035 Counter wrap: preload via 65536 pushes to channel 0 -> cnt0 returns to 16'h0000.
